// File: rtl/dma_controller_pkg.sv
// Shared widths, transfer geometry and FSM encoding for the bus-mastering DMA engine.
package dma_controller_pkg;

    localparam int unsigned WORD_SIZE   = 16;
    localparam int unsigned BURST       = 4;
    localparam int unsigned FETCH_SIZE  = BURST * WORD_SIZE;
    localparam int unsigned LENGTH      = 12;
    localparam int unsigned MEM_LATENCY = 4;
    localparam int unsigned NUM_BURSTS  = LENGTH / BURST;
    localparam int unsigned LAT_W       = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned IDX_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int unsigned OFFSET_W    = 4;

    localparam logic [WORD_SIZE-1:0] BASE_ADDR = 16'h01F4;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_XFER     = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_CLR = 3'd4
    } dma_state_e;

    // Destination word address of a block; wraps modulo 2^WORD_SIZE.
    function automatic logic [WORD_SIZE-1:0] block_addr(input logic [IDX_W-1:0] idx);
        return WORD_SIZE'(BASE_ADDR + WORD_SIZE'(idx) * WORD_SIZE'(BURST));
    endfunction

    function automatic logic [OFFSET_W-1:0] block_offset(input logic [IDX_W-1:0] idx);
        return OFFSET_W'(32'(idx) * BURST);
    endfunction

endpackage

// File: rtl/dma_burst_timer.sv
// Beat/burst counter for the DMA engine: counts MEM_LATENCY beats per block
// and NUM_BURSTS blocks per transfer, freezing whenever enable is low.
module dma_burst_timer
    import dma_controller_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             clear_i,
    input  logic             enable_i,
    output logic [IDX_W-1:0] burst_idx_o,
    output logic             last_beat_o,
    output logic             last_burst_o
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BURSTS - 1);

    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [IDX_W-1:0] burst_idx_q, burst_idx_d;
    logic             last_beat_q, last_burst_q;

    // The final beat of the final block wraps both counters back to zero.
    always_comb begin
        lat_cnt_d   = lat_cnt_q;
        burst_idx_d = burst_idx_q;
        if (clear_i) begin
            lat_cnt_d   = '0;
            burst_idx_d = '0;
        end else if (enable_i) begin
            if (last_beat_q) begin
                lat_cnt_d   = '0;
                burst_idx_d = last_burst_q ? '0 : burst_idx_q + IDX_W'(1);
            end else begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            lat_cnt_q    <= '0;
            burst_idx_q  <= '0;
            last_beat_q  <= (LAT_LAST == '0);
            last_burst_q <= (IDX_LAST == '0);
        end else begin
            lat_cnt_q    <= lat_cnt_d;
            burst_idx_q  <= burst_idx_d;
            last_beat_q  <= (lat_cnt_d == LAT_LAST);
            last_burst_q <= (burst_idx_d == IDX_LAST);
        end
    end

    assign burst_idx_o  = burst_idx_q;
    assign last_beat_o  = last_beat_q;
    assign last_burst_o = last_burst_q;

endmodule

// File: rtl/dma_controller.sv
// DMA engine sharing the CPU data-memory bus: request/grant handshake, then
// copies LENGTH device words to memory at BASE_ADDR in BURST-word blocks.
module dma_controller
    import dma_controller_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Reset_N,
    input  logic                  cmd,
    input  logic                  BG,
    output logic                  BR,
    output logic                  dma_end,
    output logic [OFFSET_W-1:0]   dev_offset,
    input  logic [FETCH_SIZE-1:0] dev_data,
    output logic                  d_writeM,
    output logic [WORD_SIZE-1:0]  d_address,
    output logic [FETCH_SIZE-1:0] d_data
);

    dma_state_e       state_q, state_d;
    logic             br_q, br_d;
    logic             dma_end_q, dma_end_d;
    logic             own_c;
    logic             timer_clear_c;
    logic [IDX_W-1:0] burst_idx;
    logic             last_beat;
    logic             last_burst;

    // Bus ownership tracks BG within the cycle so a withdrawn grant never overlaps the CPU.
    assign own_c         = (state_q == S_XFER) && BG;
    assign timer_clear_c = (state_q != S_XFER);

    dma_burst_timer u_timer (
        .Clk          (Clk),
        .Reset_N      (Reset_N),
        .clear_i      (timer_clear_c),
        .enable_i     (own_c),
        .burst_idx_o  (burst_idx),
        .last_beat_o  (last_beat),
        .last_burst_o (last_burst)
    );

    always_comb begin
        state_d   = state_q;
        br_d      = 1'b0;
        dma_end_d = 1'b0;
        unique case (state_q)
            S_IDLE:     if (cmd) state_d = S_REQ;
            S_REQ:      if (BG) state_d = S_XFER;
            S_XFER:     if (own_c && last_beat && last_burst) state_d = S_DONE;
            S_DONE:     state_d = S_WAIT_CLR;
            S_WAIT_CLR: if (!cmd) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        br_d      = (state_d == S_REQ) || (state_d == S_XFER);
        dma_end_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q   <= S_IDLE;
            br_q      <= 1'b0;
            dma_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            dma_end_q <= dma_end_d;
        end
    end

    assign BR         = br_q;
    assign dma_end    = dma_end_q;
    assign dev_offset = block_offset(burst_idx);

    assign d_writeM  = own_c ? 1'b1 : 1'bz;
    assign d_address = own_c ? block_addr(burst_idx) : {WORD_SIZE{1'bz}};
    assign d_data    = own_c ? dev_data : {FETCH_SIZE{1'bz}};

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: expected bus writes are queued by the
// stimulus and retired by a negedge monitor whenever d_writeM is asserted.
module tb_dma_controller;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
        logic [3:0]  off;
    } wr_t;

    localparam logic [15:0] EXP_ADDR [3] = '{16'h01F4, 16'h01F8, 16'h01FC};
    localparam logic [3:0]  EXP_OFF  [3] = '{4'd0, 4'd4, 4'd8};
    localparam logic [63:0] EXP_DATA [3] = '{64'h0001_0002_0003_0004,
                                             64'h0005_0006_0007_0008,
                                             64'h0009_000A_000B_000C};

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        cmd = 1'b0;
    logic        BG = 1'b0;
    logic        BR;
    logic        dma_end;
    logic [3:0]  dev_offset;
    logic [63:0] dev_data;
    wire         d_writeM;
    wire  [15:0] d_address;
    wire  [63:0] d_data;

    logic [63:0] dev_blk [4];
    wr_t         exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          wr_seen = 0;
    int          wr_start;

    always #5 Clk = ~Clk;

    dma_controller dut (
        .Clk        (Clk),
        .Reset_N    (Reset_N),
        .cmd        (cmd),
        .BG         (BG),
        .BR         (BR),
        .dma_end    (dma_end),
        .dev_offset (dev_offset),
        .dev_data   (dev_data),
        .d_writeM   (d_writeM),
        .d_address  (d_address),
        .d_data     (d_data)
    );

    // Device buffer: block selected by the requested word offset.
    assign dev_data = dev_blk[dev_offset[3:2]];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic cycle(input logic c, input logic bg);
        @(posedge Clk);
        #1;
        cmd = c;
        BG  = bg;
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back('{addr: EXP_ADDR[i/4], data: EXP_DATA[i/4], off: EXP_OFF[i/4]});
    endtask

    task automatic chk_idle_bus(input string name, input logic br_exp);
        chk({name, "_br"}, 64'(BR), 64'(br_exp));
        chk({name, "_nowrite"}, 64'(d_writeM === 1'b1), 64'd0);
    endtask

    task automatic chk_done(input string name, input int n_words);
        chk({name, "_dma_end"}, 64'(dma_end), 64'd1);
        chk({name, "_br"}, 64'(BR), 64'd0);
        chk({name, "_writes"}, 64'(wr_seen - wr_start), 64'(n_words));
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: retire one expected write per owned cycle.
    always @(negedge Clk) begin
        wr_t e;
        if (d_writeM === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h, want no write (t=%0t)", d_address, $time);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(d_address), 64'(e.addr));
                chk("wr_data", d_data, e.data);
                chk("wr_offset", 64'(dev_offset), 64'(e.off));
            end
        end
        if (dma_end === 1'b1)
            chk("end_br_exclusive", 64'(BR), 64'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        dev_blk[0] = EXP_DATA[0];
        dev_blk[1] = EXP_DATA[1];
        dev_blk[2] = EXP_DATA[2];
        dev_blk[3] = 64'hDEAD_BEEF_DEAD_BEEF;

        // Reset state, then cmd -> BR with no grant
        cycle(0, 0);
        cycle(0, 0);
        chk_idle_bus("reset", 1'b0);
        chk("reset_dma_end", 64'(dma_end), 64'd0);
        chk("reset_offset", 64'(dev_offset), 64'd0);
        Reset_N = 1'b1;
        cycle(0, 0);
        cycle(1, 0);
        chk_idle_bus("idle", 1'b0);
        cycle(0, 0);
        chk_idle_bus("req", 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0);
            chk_idle_bus("req_nogrant", 1'b1);
        end

        // Full transfer with continuous grant
        push_words(12);
        wr_start = wr_seen;
        cycle(0, 1);
        chk_idle_bus("req_grant", 1'b1);
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1);
            chk("xfer_br", 64'(BR), 64'd1);
        end
        cycle(0, 0);
        chk_done("xfer1", 12);
        cycle(0, 0);
        chk("wait_dma_end", 64'(dma_end), 64'd0);
        chk_idle_bus("wait", 1'b0);
        cycle(0, 0);

        // Grant withdrawn for 3 cycles at burst 1, lat_cnt 2
        cycle(1, 1);
        push_words(12);
        wr_start = wr_seen;
        cycle(1, 1);
        chk_idle_bus("req2", 1'b1);
        for (int i = 0; i < 6; i++)
            cycle(1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0);
            chk_idle_bus("bg_drop", 1'b1);
            chk("bg_drop_offset", 64'(dev_offset), 64'd4);
        end
        for (int i = 0; i < 6; i++)
            cycle(1, 1);
        cycle(1, 0);
        chk_done("xfer2", 12);

        // cmd held high: no restart until it drops
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0);
            chk_idle_bus("cmd_held", 1'b0);
        end
        cycle(0, 0);
        cycle(1, 0);
        chk_idle_bus("cmd_cleared", 1'b0);
        cycle(1, 1);
        chk("rearm_br", 64'(BR), 64'd1);

        // Reset during burst 2 aborts; next cmd restarts at base
        push_words(10);
        wr_start = wr_seen;
        for (int i = 0; i < 10; i++)
            cycle(1, 1);
        Reset_N = 1'b0;
        cycle(1, 1);
        chk_idle_bus("abort", 1'b0);
        chk("abort_dma_end", 64'(dma_end), 64'd0);
        chk("abort_offset", 64'(dev_offset), 64'd0);
        chk("abort_writes", 64'(wr_seen - wr_start), 64'd10);
        chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
        Reset_N = 1'b1;
        push_words(12);
        wr_start = wr_seen;
        cycle(0, 1);
        chk("restart_br", 64'(BR), 64'd1);
        for (int i = 0; i < 12; i++)
            cycle(0, 1);
        cycle(0, 0);
        chk_done("xfer3", 12);
        cycle(0, 0);
        cycle(0, 0);
        chk_idle_bus("final", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
